// File: rtl/freq_meas_pkg.sv
// Shared types and 200 MHz default limits for the frequency measurement sequencer.
package freq_meas_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_STABLE = 2'd1,
      SAMPLE      = 2'd2,
      DONE        = 2'd3
   } state_e;

   localparam int unsigned DEF_MIN_PERIOD     = 2000;
   localparam int unsigned DEF_MAX_PERIOD     = 200000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 4_000_000;

endpackage

// File: rtl/freq_avg_accum.sv
// Sample-interval timer and period accumulator; mean includes the sample on the current input.
module freq_avg_accum
   import freq_meas_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 18,
   parameter int unsigned AVG_LOG2      = 2,
   parameter int unsigned SAMPLE_GAP    = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic [COUNTER_WIDTH-1:0] period_in,
   output logic                     sample_stb,
   output logic                     last_stb,
   output logic [COUNTER_WIDTH-1:0] mean
);

   localparam int unsigned ACC_W = COUNTER_WIDTH + AVG_LOG2;
   localparam int unsigned N     = 1 << AVG_LOG2;
   localparam int unsigned GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
   localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   assign sample_stb = en && (gap_q == GAP_W'(SAMPLE_GAP - 1));
   // last_stb flags the final sample slot; only meaningful together with sample_stb
   assign last_stb   = (cnt_q == CNT_W'(N - 1));
   assign sum        = acc_q + ACC_W'(period_in);
   assign mean       = sum[ACC_W-1:AVG_LOG2];

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      gap_d = gap_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
         gap_d = '0;
      end else if (en) begin
         if (sample_stb) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
            gap_d = '0;
         end else begin
            gap_d = gap_q + GAP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         gap_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         gap_q <= gap_d;
      end
   end

endmodule

// File: rtl/freq_measure_ctrl.sv
// Measurement sequencer: waits for a stable detector, averages N period samples,
// range-checks the mean and hands it to the host with valid/ready.
module freq_measure_ctrl
   import freq_meas_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH  = 18,
   parameter int unsigned AVG_LOG2       = 2,
   parameter int unsigned SAMPLE_GAP     = 1024,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned MIN_PERIOD     = DEF_MIN_PERIOD,
   parameter int unsigned MAX_PERIOD     = DEF_MAX_PERIOD
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [COUNTER_WIDTH-1:0] period_in,
   input  logic                     stable_in,
   output logic [COUNTER_WIDTH-1:0] result_period,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic                     err_timeout,
   output logic                     err_range,
   output logic                     busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

   state_e                   state_q, state_d;
   logic [TMO_W-1:0]         tmo_q, tmo_d, tmo_inc;
   logic                     last_q, last_d;
   logic [COUNTER_WIDTH-1:0] res_q, res_d;
   logic                     etmo_q, etmo_d;
   logic                     erng_q, erng_d;

   logic                     acc_clr, acc_en, sample_stb, last_stb, tmo_hit, range_bad;
   logic [COUNTER_WIDTH-1:0] mean;

   freq_avg_accum #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .AVG_LOG2      (AVG_LOG2),
      .SAMPLE_GAP    (SAMPLE_GAP)
   ) u_accum (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (acc_clr),
      .en         (acc_en),
      .period_in  (period_in),
      .sample_stb (sample_stb),
      .last_stb   (last_stb),
      .mean       (mean)
   );

   assign tmo_inc   = tmo_q + TMO_W'(1);
   assign tmo_hit   = (tmo_inc == TMO_W'(TIMEOUT_CYCLES - 1));
   assign range_bad = (mean < COUNTER_WIDTH'(MIN_PERIOD)) || (mean > COUNTER_WIDTH'(MAX_PERIOD));

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      last_d  = last_q;
      res_d   = res_q;
      etmo_d  = etmo_q;
      erng_d  = erng_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_STABLE;
               tmo_d   = '0;
               last_d  = 1'b0;
               res_d   = '0;
               etmo_d  = 1'b0;
               erng_d  = 1'b0;
               acc_clr = 1'b1;
            end
         end
         WAIT_STABLE: begin
            tmo_d = tmo_inc;
            if (tmo_hit) begin
               state_d = DONE;
               etmo_d  = 1'b1;
               erng_d  = 1'b0;
               res_d   = '0;
            end else if (stable_in) begin
               state_d = SAMPLE;
               acc_clr = 1'b1;
            end
         end
         SAMPLE: begin
            tmo_d = tmo_inc;
            if (tmo_hit) begin
               state_d = DONE;
               etmo_d  = 1'b1;
               erng_d  = 1'b0;
               res_d   = '0;
            end else if (last_q) begin
               // all samples are in; this cycle only hands the registered mean to DONE
               state_d = DONE;
            end else if (!stable_in) begin
               state_d = WAIT_STABLE;
               acc_clr = 1'b1;
            end else begin
               acc_en = 1'b1;
               if (sample_stb && last_stb) begin
                  last_d = 1'b1;
                  res_d  = mean;
                  erng_d = range_bad;
               end
            end
         end
         DONE: begin
            if (result_ready) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         last_d  = 1'b0;
         res_d   = '0;
         etmo_d  = 1'b0;
         erng_d  = 1'b0;
         acc_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         last_q  <= 1'b0;
         res_q   <= '0;
         etmo_q  <= 1'b0;
         erng_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         last_q  <= last_d;
         res_q   <= res_d;
         etmo_q  <= etmo_d;
         erng_q  <= erng_d;
      end
   end

   assign result_period = res_q;
   assign result_valid  = (state_q == DONE);
   assign err_timeout   = etmo_q;
   assign err_range     = erng_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Directed bench for freq_measure_ctrl with small timing parameters.
module tb_freq_measure_ctrl;

   localparam int CW = 18;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          stable_in = 1'b0;
   logic          result_ready = 1'b0;
   logic [CW-1:0] period_in = '0;
   logic [CW-1:0] result_period;
   logic          result_valid, err_timeout, err_range, busy;

   int tests  = 0;
   int failed = 0;
   int n;
   logic hold_ok;

   always #5 clk = ~clk;

   freq_measure_ctrl #(
      .COUNTER_WIDTH  (CW),
      .AVG_LOG2       (2),
      .SAMPLE_GAP     (4),
      .TIMEOUT_CYCLES (100),
      .MIN_PERIOD     (10),
      .MAX_PERIOD     (1000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .period_in     (period_in),
      .stable_in     (stable_in),
      .result_period (result_period),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .err_timeout   (err_timeout),
      .err_range     (err_range),
      .busy          (busy)
   );

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pulse start and count edges (the start-sampling edge is 1) until result_valid.
   task automatic run_to_valid(output int cnt);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      cnt = 1;
      while (!result_valid && cnt < 300) begin
         tick(1);
         cnt++;
      end
   endtask

   task automatic release_result(input string tag);
      result_ready = 1'b1;
      tick(1);
      result_ready = 1'b0;
      check({tag, "_idle_busy"}, 32'(busy), 0);
      check({tag, "_idle_valid"}, 32'(result_valid), 0);
   endtask

   initial begin
      #2;
      check("rst_period", 32'(result_period), 0);
      check("rst_valid", 32'(result_valid), 0);
      check("rst_etmo", 32'(err_timeout), 0);
      check("rst_erng", 32'(err_range), 0);
      check("rst_busy", 32'(busy), 0);
      #10 rst_n = 1'b1;
      tick(1);

      // nominal constant period
      stable_in = 1'b1;
      period_in = 18'd500;
      run_to_valid(n);
      check("nom_latency", n, 19);
      check("nom_period", 32'(result_period), 500);
      check("nom_etmo", 32'(err_timeout), 0);
      check("nom_erng", 32'(err_range), 0);
      release_result("nom");

      // averaging with truncation: 100,101,102,102
      period_in = 18'd100;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      period_in = 18'd101;
      tick(4);
      period_in = 18'd102;
      tick(8);
      check("avg_not_yet", 32'(result_valid), 0);
      tick(1);
      check("avg_valid", 32'(result_valid), 1);
      check("avg_period", 32'(result_period), 101);
      check("avg_erng", 32'(err_range), 0);
      release_result("avg");

      // no signal -> timeout
      stable_in = 1'b0;
      run_to_valid(n);
      check("tmo_latency", n, 100);
      check("tmo_flag", 32'(err_timeout), 1);
      check("tmo_period", 32'(result_period), 0);
      check("tmo_erng", 32'(err_range), 0);
      release_result("tmo");

      // stable drop after two samples, recovery five cycles later
      stable_in = 1'b1;
      period_in = 18'd50;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n = 1;
      tick(9);
      n += 9;
      stable_in = 1'b0;
      period_in = 18'd300;
      tick(5);
      n += 5;
      check("drop_busy", 32'(busy), 1);
      stable_in = 1'b1;
      while (!result_valid && n < 300) begin
         tick(1);
         n++;
      end
      check("drop_latency", n, 33);
      check("drop_period", 32'(result_period), 300);
      check("drop_etmo", 32'(err_timeout), 0);
      release_result("drop");

      // out of range with backpressure
      period_in = 18'd5;
      run_to_valid(n);
      check("rng_flag", 32'(err_range), 1);
      check("rng_period", 32'(result_period), 5);
      check("rng_etmo", 32'(err_timeout), 0);
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (!(result_valid && busy && err_range && result_period == 18'd5)) hold_ok = 1'b0;
      end
      check("rng_hold", 32'(hold_ok), 1);
      release_result("rng");
      check("rng_keep_period", 32'(result_period), 5);
      check("rng_keep_flag", 32'(err_range), 1);

      // abort in SAMPLE
      period_in = 18'd500;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(7);
      check("abort_pre_busy", 32'(busy), 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_valid", 32'(result_valid), 0);
      check("abort_period", 32'(result_period), 0);
      check("abort_erng", 32'(err_range), 0);
      tick(20);
      check("abort_no_result", 32'(result_valid), 0);

      // start while in DONE is ignored
      period_in = 18'd700;
      run_to_valid(n);
      check("done_period", 32'(result_period), 700);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("done_start_valid", 32'(result_valid), 1);
      check("done_start_busy", 32'(busy), 1);
      release_result("done");
      tick(3);
      check("done_start_dropped", 32'(busy), 0);
      check("done_keep_period", 32'(result_period), 700);

      // asynchronous reset in SAMPLE
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(7);
      check("arst_pre_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_valid", 32'(result_valid), 0);
      check("arst_period", 32'(result_period), 0);
      check("arst_etmo", 32'(err_timeout), 0);
      check("arst_erng", 32'(err_range), 0);
      #3 rst_n = 1'b1;
      tick(25);
      check("arst_stays_idle", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
